// File: rtl/wheel_speed_counter.sv
// rtl/wheel_speed_counter.sv - gated wheel-pulse counter producing a saturated 8-bit speed per window
module wheel_speed_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic       overflow
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;

  // The detected edge is registered once more, so a pulse first sampled at
  // edge k lands in the pulse counter at edge k+3.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  state_t        state;
  logic [GW-1:0] gate_cnt;
  logic [7:0]    pulse_cnt;
  logic          win_ovf;
  logic [7:0]    cnt_next;
  logic          ovf_next;

  // Count including this cycle's edge; shared by counting and publishing.
  always_comb begin
    cnt_next = pulse_cnt;
    ovf_next = win_ovf;
    if (edge_q) begin
      if (pulse_cnt == 8'hFF) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = pulse_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      pulse_cnt   <= '0;
      win_ovf     <= 1'b0;
      speed       <= '0;
      speed_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt  <= '0;
          pulse_cnt <= '0;
          win_ovf   <= 1'b0;
          if (enable) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (gate_cnt == GATE_LAST) begin
            // A window that finishes as enable falls is still published.
            speed       <= cnt_next;
            overflow    <= ovf_next;
            speed_valid <= 1'b1;
            gate_cnt    <= '0;
            pulse_cnt   <= '0;
            win_ovf     <= 1'b0;
            if (!enable) begin
              state <= IDLE;
            end
          end else if (!enable) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            win_ovf   <= 1'b0;
          end else begin
            gate_cnt  <= gate_cnt + GW'(1);
            pulse_cnt <= cnt_next;
            win_ovf   <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wheel_speed_counter.sv
// tb/tb_wheel_speed_counter.sv - directed-vector bench for wheel_speed_counter
module tb_wheel_speed_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_a = 1'b1, enable_a = 1'b0, pulse_a = 1'b0;
  logic [7:0] speed_a;
  logic       valid_a, ovf_a;
  logic       clear_b = 1'b1, enable_b = 1'b0, pulse_b = 1'b0;
  logic [7:0] speed_b;
  logic       valid_b, ovf_b;

  wheel_speed_counter #(.GATE_CYCLES(20), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .clear(clear_a), .enable(enable_a), .pulse_in(pulse_a),
    .speed(speed_a), .speed_valid(valid_a), .overflow(ovf_a)
  );

  wheel_speed_counter #(.GATE_CYCLES(1100), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .clear(clear_b), .enable(enable_b), .pulse_in(pulse_b),
    .speed(speed_b), .speed_valid(valid_b), .overflow(ovf_b)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int qa_cyc[$], qa_spd[$], qa_ovf[$];
  int qb_cyc[$], qb_spd[$], qb_ovf[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: cycle number of the edge that raised speed_valid, plus outputs.
  always @(posedge clk) begin
    #1;
    if (valid_a) begin
      qa_cyc.push_back(cyc);
      qa_spd.push_back(int'(speed_a));
      qa_ovf.push_back(int'(ovf_a));
    end
    if (valid_b) begin
      qb_cyc.push_back(cyc);
      qb_spd.push_back(int'(speed_b));
      qb_ovf.push_back(int'(ovf_b));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_strobe(input string tag, input int i, input int qc[$], input int qs[$],
                              input int qo[$], input int ecyc, input int espd, input int eovf);
    if (i < qc.size()) begin
      check({tag, "_cyc"}, qc[i], ecyc);
      check({tag, "_speed"}, qs[i], espd);
      check({tag, "_ovf"}, qo[i], eovf);
    end else begin
      check({tag, "_missing"}, qc.size(), i + 1);
    end
  endtask

  task automatic flush();
    qa_cyc.delete(); qa_spd.delete(); qa_ovf.delete();
    qb_cyc.delete(); qb_spd.delete(); qb_ovf.delete();
  endtask

  int k;
  int sum;

  initial begin
    // 1: clear with pulse toggling, then idle
    @(negedge clk);
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 53; e++) begin
      if (e == k + 3) begin
        check("rst_speed", speed_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_speed_b", speed_b, 0);
      end
      clear_a  = (e < k + 3);
      clear_b  = (e < k + 3);
      enable_a = 1'b0;
      enable_b = 1'b0;
      pulse_a  = (e < k + 3) && ((e - k) % 2 == 0);
      pulse_b  = pulse_a;
      @(negedge clk);
    end
    check("idle_strobes_a", qa_cyc.size(), 0);
    check("idle_strobes_b", qb_cyc.size(), 0);
    check("idle_speed", speed_a, 0);
    check("idle_ovf", ovf_a, 0);

    // 2: pulse every 8 cycles, four windows then a partial one
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 86; e++) begin
      enable_a = (e < k + 82);
      pulse_a  = (e < k + 80) && ((e - k) % 8 < 4);
      @(negedge clk);
    end
    pulse_a = 1'b0;
    check("s2_count", qa_cyc.size(), 4);
    check_strobe("s2_w1", 0, qa_cyc, qa_spd, qa_ovf, k + 20, 3, 0);
    check_strobe("s2_w2", 1, qa_cyc, qa_spd, qa_ovf, k + 40, 2, 0);
    check_strobe("s2_w3", 2, qa_cyc, qa_spd, qa_ovf, k + 60, 3, 0);
    check_strobe("s2_w4", 3, qa_cyc, qa_spd, qa_ovf, k + 80, 2, 0);
    sum = 0;
    for (int i = 0; i < qa_spd.size() && i < 4; i++) sum += qa_spd[i];
    check("s2_sum", sum, 10);

    // 3: edge on the final window cycle, then on the first cycle after a window
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 86; e++) begin
      enable_a = (e < k + 60);
      pulse_a  = (e >= k + 17 && e <= k + 20) || (e >= k + 38 && e <= k + 41);
      @(negedge clk);
    end
    check("s3_count", qa_cyc.size(), 3);
    check_strobe("s3_last", 0, qa_cyc, qa_spd, qa_ovf, k + 20, 1, 0);
    check_strobe("s3_gap", 1, qa_cyc, qa_spd, qa_ovf, k + 40, 0, 0);
    check_strobe("s3_next", 2, qa_cyc, qa_spd, qa_ovf, k + 60, 1, 0);

    // 4: enable dropped at gate count 10 after 2 edges, then restarted
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 46; e++) begin
      if (e == k + 14) begin
        check("s4_hold_speed", speed_a, 1);
        check("s4_no_partial", qa_cyc.size(), 0);
      end
      enable_a = (e < k + 11) || (e >= k + 15 && e < k + 40);
      pulse_a  = (e - k < 2) || (e - k >= 4 && e - k < 6) ||
                 (e - k >= 20 && e - k < 22) || (e - k >= 24 && e - k < 26);
      @(negedge clk);
    end
    check("s4_count", qa_cyc.size(), 1);
    check_strobe("s4_new", 0, qa_cyc, qa_spd, qa_ovf, k + 35, 2, 0);

    // 6: clear mid-window after 5 edges with enable held high
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 51; e++) begin
      if (e == k + 22) begin
        check("s6_clr_speed", speed_a, 0);
        check("s6_clr_ovf", ovf_a, 0);
        check("s6_clr_valid", valid_a, 0);
      end
      clear_a  = (e == k + 20) || (e == k + 21);
      enable_a = (e >= k + 2 && e < k + 48);
      pulse_a  = (e < k + 20 && (e - k) % 4 < 2) || (e >= k + 30 && e < k + 32);
      @(negedge clk);
    end
    clear_a = 1'b0;
    check("s6_count", qa_cyc.size(), 1);
    check_strobe("s6_after", 0, qa_cyc, qa_spd, qa_ovf, k + 42, 1, 0);

    // 5: long window, saturation then a normal window
    k = cyc + 1;
    flush();
    for (int e = k; e < k + 2211; e++) begin
      enable_b = (e < k + 2205);
      if (e < k + 1100) pulse_b = ((e - k) % 4 < 2);
      else if (e < k + 2200) pulse_b = ((e - k - 1100) % 8 < 4);
      else pulse_b = 1'b0;
      @(negedge clk);
    end
    check("s5_count", qb_cyc.size(), 2);
    check_strobe("s5_sat", 0, qb_cyc, qb_spd, qb_ovf, k + 1100, 255, 1);
    check_strobe("s5_norm", 1, qb_cyc, qb_spd, qb_ovf, k + 2200, 138, 0);
    check("s5_a_quiet", qa_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wheel_speed_counter.md
# wheel_speed_counter

Upstream measurement stage of the cruise-control datapath. Counts rising edges of the wheel-sensor pulse over a fixed gate window and produces an 8-bit speed value with a one-cycle valid strobe. `speed` drives the `in` bus of the 8-bit parallel speed register, and `speed_valid` drives that register's `enable`, so the register updates once per window.

## Interface
- `GATE_CYCLES`, default 1000: length of the measurement window in clk cycles; must be ≥ 2.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pulse_in`; must be ≥ 2.
- `clk`  in  1: single system clock; all state changes on its rising edge.
- `clear`  in  1: synchronous, active-high reset; same net that clears the speed register.
- `enable`  in  1: measurement enable; level-sensitive.
- `pulse_in`  in  1: raw wheel-sensor pulse, asynchronous to `clk`.
- `speed`  out  8: pulse count of the last completed window, saturated at 255.
- `speed_valid`  out  1: one-cycle strobe, high in the cycle `speed` is updated.
- `overflow`  out  1: high if the last completed window saturated, i.e. had more than 255 edges.

## Operation
- Synchronizer:
  - `pulse_in` passes through `SYNC_STAGES` flops, then one history flop.
  - A rising edge is sync-last == 1 while history == 0.
  - The synchronizer runs regardless of `enable`.
  - `clear` zeroes the synchronizer and history flops.
- FSM states: IDLE and MEASURE.
  - IDLE: gate counter and pulse counter are held at 0 and edges are ignored. If `enable`=1, go to MEASURE next cycle.
  - MEASURE: gate counter increments each cycle from 0 to GATE_CYCLES-1. The pulse counter increments on each detected edge and saturates at 255; the sticky window-overflow flag is set on any edge while the count is 255.
  - MEASURE with `enable`=0: go to IDLE, discard the partial window, zero both counters, leave outputs unchanged.
- End of window (MEASURE and gate counter == GATE_CYCLES-1):
  - `speed` <= pulse count, including an edge detected in this same cycle, with saturation applied.
  - `overflow` <= window-overflow flag, including this cycle's edge.
  - `speed_valid` <= 1 for one cycle.
  - Gate counter, pulse counter and window flag restart at 0, so the next window begins with no dead cycle.
- Simultaneous end-of-window and `enable` falling: the window completes and is published, then go to IDLE.
- Priority: `clear` > `enable`=0 > end-of-window > count.
- `speed` and `overflow` hold between strobes and are never updated partially.

## Timing
- Reset values, on the clk edge where `clear`=1: `speed`=0, `speed_valid`=0, `overflow`=0, state=IDLE, all counters and sync flops 0.
- Reset mid-window: the window is aborted and nothing is published.
- Enable latency: `enable` sampled high at edge k gives MEASURE from edge k+1. The first strobe occurs at edge k+GATE_CYCLES, and every GATE_CYCLES cycles after that.
- Edge latency (SYNC_STAGES=2): `pulse_in` first sampled high at edge k has its edge counted at edge k+3.
  - An edge reaching the detector after the final window cycle counts toward the next window.
- Pulse width: `pulse_in` must be high ≥ 2 and low ≥ 2 clk cycles to guarantee detection. The maximum countable rate is one edge per 4 cycles.
- `speed_valid` is exactly one cycle wide, and `speed`/`overflow` are valid in that same cycle. The speed register therefore captures the new value on the following edge.

## Test plan
Scenarios 1–4 use GATE_CYCLES=20 and SYNC_STAGES=2.
1. `clear`=1 for 3 cycles with `pulse_in` toggling, then `clear`=0 and `enable`=0 for 50 cycles -> `speed`=0, `overflow`=0, `speed_valid` never asserted.
2. `enable`=1 and a pulse every 8 cycles (4 high, 4 low) -> `speed_valid` every 20 cycles with `speed` settling to 2 or 3. The sum over 4 consecutive windows equals the number of edges issued, so no edge is lost or double-counted.
3. Single edge timed to be detected exactly in the final window cycle -> that window reports `speed`=1. An edge detected one cycle later -> the next window reports 1.
4. `enable` dropped at gate count 10 with 2 edges counted, then raised again -> no strobe for the partial window. The next strobe occurs 20 cycles after re-entering MEASURE, and `speed` reflects only the new window.
5. GATE_CYCLES=1100 with a pulse every 4 cycles -> about 275 edges per window, so `speed`=255 and `overflow`=1. Then a pulse every 8 cycles -> next window `speed`≈137 and `overflow`=0.
6. `clear` asserted mid-window after 5 edges, `enable` held at 1 -> outputs 0 on that edge and no strobe. The FSM enters MEASURE the cycle after `clear` falls, and the first strobe comes GATE_CYCLES cycles after entry.
